// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction-memory loader.
//   LDR_T        : instruction memory address width (matches PC width)
//   LDR_IW       : instruction word width
//   LDR_BYTE_W   : host byte width
//   LDR_LEN_W    : width of the image length field
//   LDR_MAX_LEN  : largest legal image length (2^LDR_T words)
//   loader_state_t : loader FSM states
// Optional build macro: LOADER_CKSUM_EN adds the CKSUM state.
// -----------------------------------------------------------------------------
package loader_pkg;

   localparam int LDR_T       = 10;
   localparam int LDR_IW      = 9;
   localparam int LDR_BYTE_W  = 8;
   localparam int LDR_LEN_W   = 16;
   localparam int LDR_MAX_LEN = 2 ** LDR_T;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_INST_LO,
      ST_INST_HI,
      ST_DONE,
      ST_ERR
`ifdef LOADER_CKSUM_EN
      ,
      ST_CKSUM
`endif
   } loader_state_t;

endpackage

// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
// Streams a little-endian program image from a host byte port and writes
// IW-bit instruction words to instruction memory at addresses 0..N-1.
// Image: LEN_LO, LEN_HI, then N pairs of {INST_LO, INST_HI}; INST_HI carries
// inst[8] in bit 0 and must have bits [7:1] clear.
//
// Ports:
//   Clk        : clock, rising edge
//   Reset      : asynchronous active-low reset
//   Start      : one-cycle pulse, begins a load from IDLE/DONE/ERR
//   ByteIn     : host data byte
//   ByteValid  : ByteIn valid this cycle
//   ByteReady  : loader accepts ByteIn this cycle (state decode)
//   MemWrEn    : instruction memory write strobe, one cycle per word
//   MemAddr    : write address (holds when MemWrEn=0)
//   MemWrData  : write data (holds when MemWrEn=0)
//   LoadDone   : image fully written, fetch may run
//   Error      : load aborted, sticky until Start or reset
//
// Optional build macro: LOADER_CKSUM_EN -- a trailing byte equal to the XOR
// of all preceding image bytes is required before DONE.
// -----------------------------------------------------------------------------
module inst_loader
   import loader_pkg::*;
#(
   parameter int T  = LDR_T,
   parameter int IW = LDR_IW
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [LDR_BYTE_W-1:0] ByteIn,
   input  logic                  ByteValid,
   output logic                  ByteReady,
   output logic                  MemWrEn,
   output logic [T-1:0]          MemAddr,
   output logic [IW-1:0]         MemWrData,
   output logic                  LoadDone,
   output logic                  Error
);

   // One extra bit so N = 2^T is representable and never wraps.
   localparam logic [LDR_LEN_W:0] MaxLen = (LDR_LEN_W + 1)'(2 ** T);

`ifdef LOADER_CKSUM_EN
   localparam loader_state_t LastState = ST_CKSUM;
`else
   localparam loader_state_t LastState = ST_DONE;
`endif

   loader_state_t         state_q, state_d;
   logic [T:0]            idx_q, idx_d;
   logic [T:0]            idx_inc;
   logic [7:0]            len_lo_q, len_lo_d;
   logic [LDR_LEN_W-1:0]  len_q, len_d;
   logic [LDR_LEN_W-1:0]  len_full;
   logic [7:0]            lo_q, lo_d;
   logic                  wr_en_q, wr_en_d;
   logic [T-1:0]          addr_q, addr_d;
   logic [IW-1:0]         data_q, data_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  accept;
`ifdef LOADER_CKSUM_EN
   logic [7:0]            cksum_q, cksum_d;
`endif

   always_comb begin
      ByteReady = 1'b0;
      case (state_q)
         ST_LEN_LO, ST_LEN_HI, ST_INST_LO, ST_INST_HI: ByteReady = 1'b1;
`ifdef LOADER_CKSUM_EN
         ST_CKSUM:                                     ByteReady = 1'b1;
`endif
         default:                                      ByteReady = 1'b0;
      endcase
   end

   assign accept   = ByteValid && ByteReady;
   assign len_full = {ByteIn, len_lo_q};
   assign idx_inc  = idx_q + (T + 1)'(1);

   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case statement can infer a latch.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      len_lo_d = len_lo_q;
      len_d    = len_q;
      lo_d     = lo_q;
      wr_en_d  = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;
`ifdef LOADER_CKSUM_EN
      cksum_d  = cksum_q;
`endif

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (Start) begin
               state_d = ST_LEN_LO;
               idx_d   = '0;
`ifdef LOADER_CKSUM_EN
               cksum_d = '0;
`endif
            end
         end
         ST_LEN_LO: begin
            if (accept) begin
               len_lo_d = ByteIn;
               state_d  = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (accept) begin
               len_d = len_full;
               if (len_full == '0)                     state_d = LastState;
               else if ({1'b0, len_full} > MaxLen)     state_d = ST_ERR;
               else                                    state_d = ST_INST_LO;
            end
         end
         ST_INST_LO: begin
            if (accept) begin
               lo_d    = ByteIn;
               state_d = ST_INST_HI;
            end
         end
         ST_INST_HI: begin
            if (accept) begin
               if (ByteIn[7:1] != '0) begin
                  // Malformed high byte: abort without writing this word.
                  state_d = ST_ERR;
               end else begin
                  wr_en_d = 1'b1;
                  addr_d  = idx_q[T-1:0];
                  data_d  = {ByteIn[0], lo_q};
                  idx_d   = idx_inc;
                  state_d = (LDR_LEN_W'(idx_inc) == len_q) ? LastState : ST_INST_LO;
               end
            end
         end
`ifdef LOADER_CKSUM_EN
         ST_CKSUM: begin
            if (accept) state_d = (ByteIn == cksum_q) ? ST_DONE : ST_ERR;
         end
`endif
         default: state_d = ST_IDLE;
      endcase

`ifdef LOADER_CKSUM_EN
      // Running XOR covers every image byte except the checksum itself.
      if (accept && state_q != ST_CKSUM) cksum_d = cksum_q ^ ByteIn;
`endif

      // LoadDone trails DONE by a cycle so the last write lands first;
      // a Start out of DONE drops it on the same edge that leaves DONE.
      done_d = (state_q == ST_DONE) && !Start;
      err_d  = (state_d == ST_ERR);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         len_lo_q <= '0;
         len_q    <= '0;
         lo_q     <= '0;
         wr_en_q  <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef LOADER_CKSUM_EN
         cksum_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         len_lo_q <= len_lo_d;
         len_q    <= len_d;
         lo_q     <= lo_d;
         wr_en_q  <= wr_en_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         done_q   <= done_d;
         err_q    <= err_d;
`ifdef LOADER_CKSUM_EN
         cksum_q  <= cksum_d;
`endif
      end
   end

   assign MemWrEn   = wr_en_q;
   assign MemAddr   = addr_q;
   assign MemWrData = data_q;
   assign LoadDone  = done_q;
   assign Error     = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_loader
// Self-checking bench for inst_loader: directed images plus randomized images
// and randomized ByteValid gaps, checked against a byte-level image parser.
// Honours LOADER_CKSUM_EN by appending / checking the trailing XOR byte.
// -----------------------------------------------------------------------------
module tb_inst_loader;
   import loader_pkg::*;

   localparam int T  = LDR_T;
   localparam int IW = LDR_IW;

   typedef logic [7:0] byte_q_t[$];

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Start;
   logic [7:0]    ByteIn;
   logic          ByteValid;
   logic          ByteReady;
   logic          MemWrEn;
   logic [T-1:0]  MemAddr;
   logic [IW-1:0] MemWrData;
   logic          LoadDone;
   logic          Error;

   int checks = 0;
   int errors = 0;

   int exp_addr[$], exp_data[$], got_addr[$], got_data[$];
   bit exp_err;
   int exp_consumed;

   inst_loader #(.T(T), .IW(IW)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .ByteIn    (ByteIn),
      .ByteValid (ByteValid),
      .ByteReady (ByteReady),
      .MemWrEn   (MemWrEn),
      .MemAddr   (MemAddr),
      .MemWrData (MemWrData),
      .LoadDone  (LoadDone),
      .Error     (Error)
   );

   always #5 Clk = ~Clk;

   // Write monitor: every cycle with MemWrEn high is one memory write.
   always @(negedge Clk) begin
      if (MemWrEn === 1'b1) begin
         got_addr.push_back(int'(MemAddr));
         got_data.push_back(int'(MemWrData));
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference parser: which words get written, whether the load fails,
   // and how many bytes the loader consumes before it stops accepting.
   task automatic model(input byte_q_t img);
      int n;
      int p;
`ifdef LOADER_CKSUM_EN
      logic [7:0] x;
`endif
      exp_addr.delete();
      exp_data.delete();
      exp_err = 1'b0;
      n = int'(img[0]) + 256 * int'(img[1]);
      p = 2;
      if (n > LDR_MAX_LEN) begin
         exp_err = 1'b1;
         exp_consumed = 2;
         return;
      end
      for (int i = 0; i < n; i++) begin
         if (img[p+1] > 8'd1) begin
            exp_err = 1'b1;
            exp_consumed = p + 2;
            return;
         end
         exp_addr.push_back(i);
         exp_data.push_back(256 * int'(img[p+1]) + int'(img[p]));
         p += 2;
      end
`ifdef LOADER_CKSUM_EN
      x = 8'h00;
      for (int i = 0; i < p; i++) x ^= img[i];
      if (img[p] != x) exp_err = 1'b1;
      p++;
`endif
      exp_consumed = p;
   endtask

   // Appends the correct checksum byte when the feature is built in.
   task automatic finish_img(inout byte_q_t img);
`ifdef LOADER_CKSUM_EN
      logic [7:0] x;
      x = 8'h00;
      foreach (img[i]) x ^= img[i];
      img.push_back(x);
`endif
   endtask

   // mode 0: back-to-back, 1: ByteValid toggles 1/0, 2: random gaps.
   task automatic run_image(input byte_q_t img, input int mode, input string tag);
      int  guard;
      bit  ok;
      bit  idle;
      bit  phase;
      model(img);
      got_addr.delete();
      got_data.delete();
      phase = 1'b0;
      @(negedge Clk);
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      check({tag, ":start_clr_done"}, LoadDone, 0);
      check({tag, ":start_clr_err"}, Error, 0);
      for (int j = 0; j < exp_consumed; j++) begin
         ok = 1'b0;
         guard = 0;
         while (!ok && guard < 64) begin
            case (mode)
               1:       idle = phase;
               2:       idle = ($urandom_range(0, 2) == 0);
               default: idle = 1'b0;
            endcase
            phase = ~phase;
            ByteValid = !idle;
            ByteIn = idle ? 8'($urandom) : img[j];
            ok = !idle && (ByteReady === 1'b1);
            @(negedge Clk);
            guard++;
         end
         if (!ok) begin
            check({tag, ":byte_accept"}, ok, 1);
            break;
         end
      end
      ByteValid = 1'b0;
      // First negedge after the final accept edge.
      if (!exp_err) begin
         check({tag, ":done_not_early"}, LoadDone, 0);
         @(negedge Clk);
         check({tag, ":done_rise"}, LoadDone, 1);
         check({tag, ":no_error"}, Error, 0);
      end else begin
         @(negedge Clk);
         check({tag, ":error_set"}, Error, 1);
         check({tag, ":no_done"}, LoadDone, 0);
      end
      check({tag, ":ready_low"}, ByteReady, 0);
      repeat (3) @(negedge Clk);
      check({tag, ":status_held"}, {LoadDone, Error}, exp_err ? 2'b01 : 2'b10);
      check({tag, ":write_count"}, got_addr.size(), exp_addr.size());
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
         check($sformatf("%s:addr%0d", tag, i), got_addr[i], exp_addr[i]);
         check($sformatf("%s:data%0d", tag, i), got_data[i], exp_data[i]);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ":ByteReady"}, ByteReady, 0);
      check({tag, ":MemWrEn"}, MemWrEn, 0);
      check({tag, ":MemAddr"}, MemAddr, 0);
      check({tag, ":MemWrData"}, MemWrData, 0);
      check({tag, ":LoadDone"}, LoadDone, 0);
      check({tag, ":Error"}, Error, 0);
   endtask

   initial begin : main
      byte_q_t img;
      byte_q_t base;
      int      n;
      Reset = 1'b0;
      Start = 1'b0;
      ByteValid = 1'b0;
      ByteIn = 8'h00;
      #12;
      check_all_zero("reset");
      @(negedge Clk);
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      check("idle_ready", ByteReady, 0);

      // Directed three-word image, back to back.
      base = '{8'h03, 8'h00, 8'hAA, 8'h00, 8'h55, 8'h01, 8'hFF, 8'h01};
      img = base;
      finish_img(img);
      run_image(img, 0, "basic");

      // Reset three bytes into a new load: outputs drop without a clock.
      @(negedge Clk);
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      ByteValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ByteIn = base[i];
         @(negedge Clk);
      end
      got_addr.delete();
      #2 Reset = 1'b0;
      #1 check_all_zero("async_reset");
      ByteValid = 1'b0;
      @(negedge Clk);
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      check("post_reset_ready", ByteReady, 0);
      check("post_reset_writes", got_addr.size(), 0);

      // Same image with ByteValid toggling.
      run_image(img, 1, "toggle");

      // Zero length and oversize length.
      img = '{8'h00, 8'h00};
      finish_img(img);
      run_image(img, 0, "len0");
      img = '{8'h01, 8'h04};
      run_image(img, 0, "len_big");

      // Bad high byte on word 2, then a clean reload.
      img = '{8'h03, 8'h00, 8'hAA, 8'h00, 8'h55, 8'h01, 8'h77, 8'h03};
      run_image(img, 0, "bad_hi");
      img = base;
      finish_img(img);
      run_image(img, 2, "reload");

`ifdef LOADER_CKSUM_EN
      img = '{8'h01, 8'h00, 8'h12, 8'h01, 8'h12};
      run_image(img, 0, "ck_ok");
      img = '{8'h01, 8'h00, 8'h12, 8'h01, 8'h13};
      run_image(img, 0, "ck_bad");
`endif

      // Randomized images with random gaps and occasional bad bytes.
      for (int r = 0; r < 12; r++) begin
         n = $urandom_range(1, 6);
         img = {};
         img.push_back(8'(n));
         img.push_back(8'h00);
         for (int i = 0; i < n; i++) begin
            img.push_back(8'($urandom));
            if ($urandom_range(0, 9) == 0) img.push_back(8'($urandom_range(2, 255)));
            else                            img.push_back(8'($urandom_range(0, 1)));
         end
         finish_img(img);
`ifdef LOADER_CKSUM_EN
         if ($urandom_range(0, 3) == 0) img[img.size()-1] ^= 8'($urandom_range(1, 255));
`endif
         run_image(img, 2, $sformatf("rand%0d", r));
      end

      // Full-size image: last address is 2^T-1 with no wrap.
      img = {};
      img.push_back(8'(LDR_MAX_LEN % 256));
      img.push_back(8'(LDR_MAX_LEN / 256));
      for (int i = 0; i < LDR_MAX_LEN; i++) begin
         img.push_back(8'($urandom));
         img.push_back(8'($urandom_range(0, 1)));
      end
      finish_img(img);
      run_image(img, 0, "full");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
